counter_timer_ctrl: RTL and testbench
=====================================

Name: counter_timer_ctrl

Overview:
Sequencing controller for the 8-bit loadable up-counter (`counter`: ports out, cout, data, load, clk; no reset). It turns that counter into a programmable interval timer.
- Modes: one-shot and auto-reload.
- Controls: start, stop and pause/resume.
- Outputs: expiry tick, sticky interrupt with acknowledge, and a saturating expiry count.
- The controller drives `load`/`data` and observes `out`/`cout`. It sits between the register/control logic and the counter instance.

Parameters:
WIDTH, 8, counter width; must equal the counter instance width (8).

Ports:
clk       in   1      system clock, rising edge
rst_n     in   1      asynchronous active-low reset
start     in   1      start request (pulse), sampled in IDLE only
stop      in   1      stop request (level)
pause     in   1      hold request (level)
mode      in   1      0 = one-shot, 1 = auto-reload
period    in   WIDTH  interval length P in cycles; 0 means 256
irq_ack   in   1      clear irq
cnt_out   in   WIDTH  from counter.out
cnt_cout  in   1      from counter.cout (1 when out == 8'hFF)
cnt_load  out  1      to counter.load
cnt_data  out  WIDTH  to counter.data
busy      out  1      state is RUN or PAUSE
tick      out  1      one-cycle registered expiry pulse
irq       out  1      sticky expiry flag
tick_cnt  out  WIDTH  expiries since last start, saturates at 8'hFF

Behaviour:
- Counter contract:
  - load=1: out <= data.
  - load=0: out <= out+1, wrapping FF->00.
  - cout = (out == 8'hFF).
  - The counter has no reset, so the controller's IDLE load defines its contents.
- Load value: L = -P mod 256 (two's complement of period). Counting L..FF takes exactly P cycles; P=0 gives L=0 and 256 cycles.
- States: IDLE, RUN, PAUSE. Async reset goes to IDLE.
- Reset values: busy=0, tick=0, irq=0, tick_cnt=0, period_q=0.
- Reset at any time, including mid-run: outputs take reset values immediately. Because the state is IDLE, cnt_load=1 and the counter is re-initialised on the first clock.
- cnt_load / cnt_data (combinational from state and inputs):
  - IDLE: load=1, data = -period (live input).
  - RUN: load = cnt_cout & mode & !stop, data = -period_q.
  - PAUSE: load=1, data = cnt_out (hold).
- IDLE:
  - start & !stop: period_q <= period, tick_cnt <= 0, go to RUN. The counter holds L in the first RUN cycle.
  - start & stop together: stop wins, stay in IDLE.
- RUN, evaluated in priority order:
  1. Expiry (cnt_cout=1): tick <= 1 next cycle, tick_cnt <= sat(+1).
     - mode=1 & !stop: counter reloads to L, stay in RUN.
     - Otherwise (one-shot, or stop asserted): go to IDLE.
     - Expiry takes precedence over pause; pause is honoured on the following cycle.
  2. stop: go to IDLE, no tick.
  3. pause: go to PAUSE. The counter increments once on this edge, then holds.
- PAUSE:
  - stop: go to IDLE.
  - !pause: go to RUN.
  - A pause sampled high for N consecutive edges delays expiry by exactly N cycles.
- start is ignored in RUN and PAUSE. period and mode changes mid-run: period is ignored (period_q is latched at start); mode is sampled live at each expiry.
- Latency: start sampled at edge k means cnt_out=L in cycle k+1, cnt_cout in cycle k+P, tick high in cycle k+P+1. In auto-reload, ticks are exactly P cycles apart.
- irq: set on tick, cleared by irq_ack. If set and ack coincide, set wins.

Decomposition:
- Shared include timer_defs.vh:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2
  - MODE_ONESHOT=1'b0, MODE_RELOAD=1'b1
- Sub-module: the existing `counter`, instantiated in a wrapper counter_timer (controller plus counter).
- The controller itself stays a single FSM module.

Test Plan:
1. Reset, then period=4, mode=1, start pulse at edge k -> tick at cycles k+5, k+9, k+13; tick_cnt 1, 2, 3; busy=1 throughout.
2. period=0, mode=0, start -> exactly one tick at k+257; busy falls at the same time; irq=1 until irq_ack, then 0.
3. period=10, mode=1, pause high for 3 edges starting at cnt_out=L+2 -> cnt_out frozen during PAUSE; next tick delayed by exactly 3 cycles versus the unpaused reference.
4. period=5, mode=1, stop asserted in the cnt_cout cycle -> that tick is still issued, tick_cnt incremented, state goes to IDLE, no further ticks, cnt_load=1.
5. irq_ack asserted in the same cycle irq is set -> irq remains 1; ack on the next cycle clears it. Separately, 300 ticks at period=1 -> tick_cnt saturates at 8'hFF.
6. rst_n pulled low asynchronously mid-RUN (between edges) -> busy, tick, irq, tick_cnt are 0 immediately and cnt_load=1. After release, start runs a normal first interval.

Source files
------------

// File: rtl/counter_timer_ctrl_pkg.sv
// Shared types and helpers for the interval-timer controller that sequences
// the external 8-bit loadable up-counter.
package counter_timer_ctrl_pkg;

  localparam int WIDTH_C = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  // Counting from -P up to all-ones takes exactly P cycles (P=0 gives a full wrap).
  function automatic logic [WIDTH_C-1:0] load_value(input logic [WIDTH_C-1:0] p);
    return {WIDTH_C{1'b0}} - p;
  endfunction

  function automatic logic [WIDTH_C-1:0] sat_inc(input logic [WIDTH_C-1:0] v);
    return (v == {WIDTH_C{1'b1}}) ? v : v + {{(WIDTH_C-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/counter_timer_ctrl.sv
// Interval-timer FSM: drives load/data of the free-running counter and turns
// its carry-out into ticks, a sticky irq and a saturating expiry count.
module counter_timer_ctrl
  import counter_timer_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic             irq_ack,
  input  logic [WIDTH-1:0] cnt_out,
  input  logic             cnt_cout,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  output logic             busy,
  output logic             tick,
  output logic             irq,
  output logic [WIDTH-1:0] tick_cnt
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_period_q;
  logic [WIDTH-1:0] r_tick_cnt;
  logic             r_tick;
  logic             r_irq;
  logic             w_expire;
  logic             w_start_ok;

  // Next-state decode and counter drive; expiry outranks stop and pause in RUN
  always_comb begin
    w_next     = r_state;
    cnt_load   = 1'b1;
    cnt_data   = load_value(period);
    w_expire   = 1'b0;
    w_start_ok = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_start_ok = 1'b1;
          w_next     = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_load = cnt_cout && (mode == MODE_RELOAD) && !stop;
        cnt_data = load_value(r_period_q);
        if (cnt_cout) begin
          w_expire = 1'b1;
          if ((mode == MODE_RELOAD) && !stop) begin
            w_next = ST_RUN;
          end else begin
            w_next = ST_IDLE;
          end
        end else if (stop) begin
          w_next = ST_IDLE;
        end else if (pause) begin
          w_next = ST_PAUSE;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_PAUSE: begin
        cnt_data = cnt_out;
        if (stop) begin
          w_next = ST_IDLE;
        end else if (!pause) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_PAUSE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, latched period, tick pulse, expiry count and sticky irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_period_q <= {WIDTH{1'b0}};
      r_tick_cnt <= {WIDTH{1'b0}};
      r_tick     <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tick  <= w_expire;
      if (w_start_ok) begin
        r_period_q <= period;
        r_tick_cnt <= {WIDTH{1'b0}};
      end else if (w_expire) begin
        r_tick_cnt <= sat_inc(r_tick_cnt);
      end else begin
        r_tick_cnt <= r_tick_cnt;
      end
      // a new expiry beats a simultaneous acknowledge
      if (w_expire) begin
        r_irq <= 1'b1;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
      end else begin
        r_irq <= r_irq;
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign tick     = r_tick;
  assign irq      = r_irq;
  assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed bench for counter_timer_ctrl with a behavioural model of the
// 8-bit loadable counter closing the loop.
module tb_counter_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic       irq_ack = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] cnt_out;
  logic       cnt_cout;
  logic       cnt_load;
  logic [7:0] cnt_data;
  logic       busy;
  logic       tick;
  logic       irq;
  logic [7:0] tick_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int ticks;

  counter_timer_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .period   (period),
    .irq_ack  (irq_ack),
    .cnt_out  (cnt_out),
    .cnt_cout (cnt_cout),
    .cnt_load (cnt_load),
    .cnt_data (cnt_data),
    .busy     (busy),
    .tick     (tick),
    .irq      (irq),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  // Counter model: no reset, load or increment with wrap
  always @(posedge clk) cnt_out <= cnt_load ? cnt_data : cnt_out + 8'd1;
  assign cnt_cout = (cnt_out == 8'hFF);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] p, input logic m);
    period = p;
    mode   = m;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_tick_cnt", 32'(tick_cnt), 32'd0);
    check_val("rst_load", 32'(cnt_load), 32'd1);
    #3 rst_n = 1'b1;
    step();

    // 1: auto-reload P=4, ticks every 4 edges
    do_start(8'd4, 1'b1);
    check_val("t1_first_L", 32'(cnt_out), 32'hFC);
    for (int i = 1; i <= 12; i++) begin
      step();
      check_val("t1_tick", 32'(tick), 32'(i % 4 == 0));
      check_val("t1_tick_cnt", 32'(tick_cnt), i / 4);
      check_val("t1_busy", 32'(busy), 32'd1);
    end
    check_val("t1_irq", 32'(irq), 32'd1);
    do_stop();
    check_val("t1_stopped", 32'(busy), 32'd0);

    // 2: one-shot P=0 -> 256 cycles, single tick, busy drops with it
    ack_irq();
    check_val("t2_irq_clr", 32'(irq), 32'd0);
    do_start(8'd0, 1'b0);
    check_val("t2_first_L", 32'(cnt_out), 32'h00);
    ticks = 0;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (tick) ticks++;
      if (i == 255) begin
        check_val("t2_busy_255", 32'(busy), 32'd1);
        check_val("t2_tick_255", 32'(tick), 32'd0);
      end
      if (i == 256) begin
        check_val("t2_tick_256", 32'(tick), 32'd1);
        check_val("t2_busy_256", 32'(busy), 32'd0);
        check_val("t2_irq_256", 32'(irq), 32'd1);
        check_val("t2_cnt_256", 32'(tick_cnt), 32'd1);
      end
    end
    check_val("t2_tick_count", ticks, 32'd1);
    check_val("t2_irq_sticky", 32'(irq), 32'd1);
    ack_irq();
    check_val("t2_irq_acked", 32'(irq), 32'd0);

    // 3: P=10 reload, pause for 3 edges from L+2 -> tick moves from edge 10 to 13
    do_start(8'd10, 1'b1);
    check_val("t3_first_L", 32'(cnt_out), 32'hF6);
    for (int e = 1; e <= 14; e++) begin
      pause = (e >= 3 && e <= 5);
      step();
      if (e >= 3 && e <= 6) check_val("t3_frozen", 32'(cnt_out), 32'hF9);
      if (e == 4) check_val("t3_busy_paused", 32'(busy), 32'd1);
      check_val("t3_tick", 32'(tick), 32'(e == 13));
    end
    pause = 1'b0;
    do_stop();

    // 4: stop during the carry cycle still yields the tick, then idles
    ack_irq();
    do_start(8'd5, 1'b1);
    for (int i = 1; i <= 4; i++) step();
    check_val("t4_cout", 32'(cnt_cout), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_val("t4_tick", 32'(tick), 32'd1);
    check_val("t4_tick_cnt", 32'(tick_cnt), 32'd1);
    check_val("t4_busy", 32'(busy), 32'd0);
    check_val("t4_load", 32'(cnt_load), 32'd1);
    ticks = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (tick) ticks++;
    end
    check_val("t4_no_more_ticks", ticks, 32'd0);

    // 5a: ack coinciding with set leaves irq high; next ack clears
    ack_irq();
    check_val("t5_irq_pre", 32'(irq), 32'd0);
    do_start(8'd3, 1'b0);
    step();
    step();
    check_val("t5_cout", 32'(cnt_cout), 32'd1);
    irq_ack = 1'b1;
    step();
    check_val("t5_set_wins", 32'(irq), 32'd1);
    check_val("t5_tick", 32'(tick), 32'd1);
    step();
    irq_ack = 1'b0;
    check_val("t5_ack_clears", 32'(irq), 32'd0);

    // 5b: P=1 reload ticks every cycle, count saturates
    do_start(8'd1, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) check_val("t5_cnt_254", 32'(tick_cnt), 32'hFE);
    end
    check_val("t5_sat", 32'(tick_cnt), 32'hFF);
    check_val("t5_tick_every", 32'(tick), 32'd1);
    do_stop();

    // 6: async reset mid-run, then a clean first interval
    ack_irq();
    do_start(8'd8, 1'b1);
    for (int i = 1; i <= 8; i++) step();
    check_val("t6_pre_tick", 32'(tick), 32'd1);
    check_val("t6_pre_irq", 32'(irq), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_tick", 32'(tick), 32'd0);
    check_val("t6_irq", 32'(irq), 32'd0);
    check_val("t6_tick_cnt", 32'(tick_cnt), 32'd0);
    check_val("t6_load", 32'(cnt_load), 32'd1);
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    do_start(8'd8, 1'b1);
    check_val("t6_first_L", 32'(cnt_out), 32'hF8);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_val("t6_tick_seq", 32'(tick), 32'(i == 8));
    end
    check_val("t6_tick_cnt_after", 32'(tick_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
